// File: rtl/clock_div_block.sv
`default_nettype none
// ============================================================================
// Module      : clock_div_block
// Description : Multi-channel programmable clock divider. Each channel
//               produces a registered 50%-duty divided clock with a
//               half-period of div_i clk cycles. A div_i value of 0 is
//               treated as 1. Each channel also produces a rising-edge tick
//               and an activity flag.
//               A stopping channel drains its high phase before it goes
//               idle. A global align pulse restarts the phase of every
//               running channel.
// Ports       : clk    - single clock, rising edge
//               rst_n  - synchronous active-low reset
//               en     - per-channel run request (level)
//               div    - per-channel half-period, channel i at [i*DIV_W +: DIV_W]
//               align  - one-cycle pulse, restarts phase of busy channels
//               o      - divided clock outputs (registered)
//               tick   - one-cycle pulse after each rising edge of o[i]
//               active - channel i is running or draining
// Revision    : 1.0 - initial release
// ============================================================================
(* whitebox *)
module clock_div_block #(
    parameter int N_OUT = 2,
    parameter int DIV_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_OUT-1:0]       en,
    input  logic [N_OUT*DIV_W-1:0] div,
    input  logic                   align,
    (* CLOCK *)
    output logic [N_OUT-1:0]       o,
    output logic [N_OUT-1:0]       tick,
    output logic [N_OUT-1:0]       active
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_stop = 2'd2;

    localparam logic [DIV_W-1:0] c_zero = '0;
    localparam logic [DIV_W-1:0] c_one  = DIV_W'(1);

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_ch
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] w_cnt_nxt;
        logic [DIV_W-1:0] r_shadow;
        logic [DIV_W-1:0] w_shadow_nxt;
        logic [DIV_W-1:0] w_div;
        logic [DIV_W-1:0] w_half;
        logic             r_o;
        logic             w_o_nxt;
        logic             r_tick;
        logic             w_tick_nxt;
        logic             r_active;
        logic             w_wrap;
        logic             w_busy;

        assign w_div  = div[gi*DIV_W +: DIV_W];
        assign w_half = (w_div == c_zero) ? c_one : w_div;
        // Shadow is never 0, so shadow-1 cannot underflow.
        assign w_wrap = (r_cnt == (r_shadow - c_one));
        assign w_busy = (r_state != c_st_idle);

        // ---------------- state register ----------------
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= c_st_idle;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // ---------------- next-state logic ----------------
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                c_st_idle: begin
                    if (en[gi]) w_state_nxt = c_st_run;
                end
                c_st_run: begin
                    if (align) begin
                        w_state_nxt = c_st_run;
                    end else if (!en[gi] && !r_o) begin
                        // Low phase is simply truncated; o is already low.
                        w_state_nxt = c_st_idle;
                    end else if (!en[gi]) begin
                        // High phase must finish; if it ends on this edge, go straight idle.
                        w_state_nxt = w_wrap ? c_st_idle : c_st_stop;
                    end
                end
                c_st_stop: begin
                    if (align) begin
                        w_state_nxt = c_st_idle;
                    end else if (w_wrap) begin
                        w_state_nxt = en[gi] ? c_st_run : c_st_idle;
                    end else if (en[gi]) begin
                        w_state_nxt = c_st_run;
                    end
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end

        // ---------------- output / datapath next values ----------------
        always_comb begin
            w_cnt_nxt    = r_cnt;
            w_shadow_nxt = r_shadow;
            w_o_nxt      = r_o;
            w_tick_nxt   = 1'b0;
            if (align && w_busy) begin
                w_cnt_nxt    = c_zero;
                w_shadow_nxt = w_half;
                w_o_nxt      = 1'b0;
            end else if (!w_busy) begin
                w_cnt_nxt = c_zero;
                w_o_nxt   = 1'b0;
                if (en[gi]) w_shadow_nxt = w_half;
            end else if ((r_state == c_st_run) && !en[gi] && !r_o) begin
                w_cnt_nxt = c_zero;
            end else if (w_wrap) begin
                // Phase boundary: toggle, restart count, pick up the new divisor.
                w_o_nxt      = ~r_o;
                w_tick_nxt   = ~r_o;
                w_cnt_nxt    = c_zero;
                w_shadow_nxt = w_half;
            end else begin
                w_cnt_nxt = r_cnt + c_one;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt    <= c_zero;
                r_shadow <= c_one;
                r_o      <= 1'b0;
                r_tick   <= 1'b0;
                r_active <= 1'b0;
            end else begin
                r_cnt    <= w_cnt_nxt;
                r_shadow <= w_shadow_nxt;
                r_o      <= w_o_nxt;
                r_tick   <= w_tick_nxt;
                r_active <= (w_state_nxt != c_st_idle);
            end
        end

        assign o[gi]      = r_o;
        assign tick[gi]   = r_tick;
        assign active[gi] = r_active;
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_div_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_div_block
// Description : Scoreboard bench for clock_div_block (N_OUT=2, DIV_W=4).
//               A countdown-based reference model predicts o/tick/active
//               after every clock edge and queues the prediction. A monitor
//               pops each prediction on the falling edge and compares it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_div_block;

    localparam int N_OUT = 2;
    localparam int DIV_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_OUT-1:0]       en;
    logic [N_OUT*DIV_W-1:0] div;
    logic                   align;
    logic [N_OUT-1:0]       o;
    logic [N_OUT-1:0]       tick;
    logic [N_OUT-1:0]       active;

    int n_checks = 0;
    int n_errors = 0;

    logic [3*N_OUT-1:0] exp_q[$];

    // Reference model state: remaining edges until the next toggle.
    int left [N_OUT];
    bit busy [N_OUT];
    bit lvl  [N_OUT];
    bit drn  [N_OUT];
    bit tk   [N_OUT];

    clock_div_block #(
        .N_OUT(N_OUT),
        .DIV_W(DIV_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .div   (div),
        .align (align),
        .o     (o),
        .tick  (tick),
        .active(active)
    );

    always #5 clk = ~clk;

    function automatic int heff(input int c);
        int d;
        d = int'(div[c*DIV_W +: DIV_W]);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_step();
        logic [N_OUT-1:0] oe, te, ae;
        for (int c = 0; c < N_OUT; c++) begin
            tk[c] = 1'b0;
            if (!rst_n) begin
                busy[c] = 1'b0; lvl[c] = 1'b0; drn[c] = 1'b0; left[c] = 0;
            end else if (align && busy[c]) begin
                lvl[c]  = 1'b0;
                left[c] = heff(c);
                if (drn[c]) begin busy[c] = 1'b0; drn[c] = 1'b0; end
            end else if (!busy[c]) begin
                if (en[c]) begin
                    busy[c] = 1'b1; lvl[c] = 1'b0; drn[c] = 1'b0; left[c] = heff(c);
                end
            end else if (!en[c] && !lvl[c]) begin
                busy[c] = 1'b0; drn[c] = 1'b0;
            end else begin
                drn[c]  = !en[c];
                left[c] = left[c] - 1;
                if (left[c] == 0) begin
                    lvl[c]  = !lvl[c];
                    tk[c]   = lvl[c];
                    left[c] = heff(c);
                    if (!lvl[c] && drn[c]) begin busy[c] = 1'b0; drn[c] = 1'b0; end
                end
            end
            oe[c] = lvl[c];
            te[c] = tk[c];
            ae[c] = busy[c];
        end
        exp_q.push_back({oe, te, ae});
    endtask

    task automatic chk(input string nm, input logic [N_OUT-1:0] act, input logic [N_OUT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Model: evaluate at each rising edge with the inputs the DUT samples.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare DUT outputs on the falling edge.
    initial begin
        logic [3*N_OUT-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("o",      o,      e[3*N_OUT-1:2*N_OUT]);
                chk("tick",   tick,   e[2*N_OUT-1:N_OUT]);
                chk("active", active, e[N_OUT-1:0]);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_div(input int c, input int v);
        div[c*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    initial begin
        // Reset held two cycles with both channels requested.
        rst_n = 1'b0; en = 2'b11; align = 1'b0; div = '0;
        set_div(0, 3); set_div(1, 5);
        run(2);
        // Release with only channel 0 running at half-period 3.
        rst_n = 1'b1; en = 2'b01;
        run(14);
        // Stop, then divisor 0 (fastest rate).
        en = 2'b00; run(6);
        set_div(0, 0); en = 2'b01; run(8);
        // Divisor change mid-phase takes effect at the next toggle.
        en = 2'b00; run(4);
        set_div(0, 3); en = 2'b01; run(4);
        set_div(0, 5); run(22);
        // Drop enable during high phase, with and without reassertion.
        en = 2'b00; run(4);
        set_div(0, 4); en = 2'b01; run(10);
        en = 2'b00; run(1);
        en = 2'b01; run(14);
        en = 2'b00; run(6);
        // Both channels running, then align.
        set_div(0, 3); set_div(1, 5); en = 2'b11; run(13);
        align = 1'b1; run(1);
        align = 1'b0; run(14);
        // Reset pulse mid-run with enable still high.
        rst_n = 1'b0; run(1);
        rst_n = 1'b1; run(12);
        // Maximum divisor.
        set_div(0, 15); set_div(1, 1); run(40);
        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            align = ($urandom_range(0, 39) == 0);
            for (int b = 0; b < N_OUT; b++) begin
                if ($urandom_range(0, 9) == 0) en[b] = ~en[b];
                if ($urandom_range(0, 19) == 0) set_div(b, int'($urandom_range(0, 15)));
            end
            run(1);
        end
        align = 1'b0; rst_n = 1'b1;
        run(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
